// File: rtl/sysid_check_ctrl.sv
// ---------------------------------------------------------------------------
// sysid_check_ctrl
//
// Boot-time sequencer for the system-ID slave. After reset (when AUTO_START
// is set) or on a start pulse it reads the system ID word (addr 0) and the
// build timestamp word (addr 1), compares them with the expected build
// values and retries after an idle gap on mismatch. The result is published
// as sticky sys_ok / sys_err flags together with the captured words. The CPU
// boot code polls sys_ok before loading the application.
//
// Ports
//   clock           in   1   system clock
//   reset_n         in   1   asynchronous active-low reset
//   start           in   1   one-cycle pulse requesting a (re)check
//   sysid_address   out  1   address to the sysid slave (0 when idle)
//   sysid_read      out  1   read strobe, one cycle per access
//   sysid_readdata  in   32  read data from the sysid slave
//   busy            out  1   check in progress, retry gaps included
//   sys_ok          out  1   last check passed (sticky until next trigger)
//   sys_err         out  1   last check failed after all retries (sticky)
//   id_word         out  32  last captured addr-0 word
//   ts_word         out  32  last captured addr-1 word
//   retry_count     out  4   attempts beyond the first used by the last check
//
// Every output comes straight from a flop. The bus strobe and address are
// derived from the next state, so a strobe is visible in exactly the cycle
// the FSM spends in RD_ID / RD_TS, and an asserted reset_n drops it at once.
// ---------------------------------------------------------------------------
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1571410521,
    parameter int unsigned CHECK_TS     = 1,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RETRY_GAP    = 16,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        sys_ok,
    output logic        sys_err,
    output logic [31:0] id_word,
    output logic [31:0] ts_word,
    output logic [3:0]  retry_count
);

    // FSM encoding
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_RD_ID = 4'd1;
    localparam logic [3:0] ST_WT_ID = 4'd2;
    localparam logic [3:0] ST_RD_TS = 4'd3;
    localparam logic [3:0] ST_WT_TS = 4'd4;
    localparam logic [3:0] ST_CMP   = 4'd5;
    localparam logic [3:0] ST_GAP   = 4'd6;
    localparam logic [3:0] ST_PASS  = 4'd7;
    localparam logic [3:0] ST_FAIL  = 4'd8;

    // Parameter-derived constants at the widths the datapath uses
    localparam logic [1:0] LAT_C       = 2'(READ_LATENCY);
    localparam logic       LAT_ZERO_C  = (READ_LATENCY == 0) ? 1'b1 : 1'b0;
    localparam logic       TS_EN_C     = (CHECK_TS != 0) ? 1'b1 : 1'b0;
    localparam logic       AUTO_C      = (AUTO_START != 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
    // The gap counter is loaded with N-1 and counts down to 0, giving N cycles.
    localparam logic [7:0] GAP_LOAD_C  = 8'(RETRY_GAP - 1);

    // Compare captured words against the build values; the timestamp is
    // ignored when timestamp checking is disabled.
    function automatic logic words_match(input logic [31:0] id_w,
                                         input logic [31:0] ts_w);
        logic id_ok;
        logic ts_ok;
        id_ok = (id_w == EXPECTED_ID);
        ts_ok = (!TS_EN_C) || (ts_w == EXPECTED_TS);
        return id_ok & ts_ok;
    endfunction

    logic [3:0]  state_r;
    logic [3:0]  next_state_s;
    logic [1:0]  wait_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic [3:0]  retry_r;
    logic        auto_pend_r;
    logic        read_r;
    logic        addr_r;
    logic        busy_r;
    logic        ok_r;
    logic        err_r;
    logic [31:0] id_r;
    logic [31:0] ts_r;

    logic        idle_like_s;
    logic        trigger_s;
    logic        wait_done_s;
    logic        capture_id_s;
    logic        capture_ts_s;
    logic        match_s;
    logic        can_retry_s;

    // Trigger, capture strobes and compare result
    always_comb begin
        idle_like_s  = 1'b0;
        trigger_s    = 1'b0;
        wait_done_s  = 1'b0;
        capture_id_s = 1'b0;
        capture_ts_s = 1'b0;
        match_s      = 1'b0;
        can_retry_s  = 1'b0;

        if ((state_r == ST_IDLE) || (state_r == ST_PASS) || (state_r == ST_FAIL)) begin
            idle_like_s = 1'b1;
        end else begin
            idle_like_s = 1'b0;
        end

        // start while busy is simply not looked at: no restart, no queueing.
        trigger_s   = idle_like_s & (start | auto_pend_r);
        wait_done_s = (wait_cnt_r == LAT_C);

        // Data is valid READ_LATENCY cycles after the strobe; with zero
        // latency that is the strobe cycle itself.
        if (LAT_ZERO_C) begin
            capture_id_s = (state_r == ST_RD_ID);
            capture_ts_s = (state_r == ST_RD_TS);
        end else begin
            capture_id_s = (state_r == ST_WT_ID) & wait_done_s;
            capture_ts_s = (state_r == ST_WT_TS) & wait_done_s;
        end

        match_s     = words_match(id_r, ts_r);
        can_retry_s = (retry_r < MAX_RETRY_C);
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (trigger_s) begin
                    next_state_s = ST_RD_ID;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RD_ID: begin
                if (LAT_ZERO_C) begin
                    next_state_s = ST_RD_TS;
                end else begin
                    next_state_s = ST_WT_ID;
                end
            end
            ST_WT_ID: begin
                if (wait_done_s) begin
                    next_state_s = ST_RD_TS;
                end else begin
                    next_state_s = ST_WT_ID;
                end
            end
            ST_RD_TS: begin
                if (LAT_ZERO_C) begin
                    next_state_s = ST_CMP;
                end else begin
                    next_state_s = ST_WT_TS;
                end
            end
            ST_WT_TS: begin
                if (wait_done_s) begin
                    next_state_s = ST_CMP;
                end else begin
                    next_state_s = ST_WT_TS;
                end
            end
            ST_CMP: begin
                if (match_s) begin
                    next_state_s = ST_PASS;
                end else if (can_retry_s) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_FAIL;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 8'd0) begin
                    next_state_s = ST_RD_ID;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, one-shot auto-start request and registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            auto_pend_r <= AUTO_C;
            read_r      <= 1'b0;
            addr_r      <= 1'b0;
            busy_r      <= 1'b0;
            ok_r        <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            auto_pend_r <= 1'b0;
            read_r      <= (next_state_s == ST_RD_ID) || (next_state_s == ST_RD_TS);
            addr_r      <= (next_state_s == ST_RD_TS);
            busy_r      <= (next_state_s != ST_IDLE) && (next_state_s != ST_PASS) &&
                           (next_state_s != ST_FAIL);
            // PASS and FAIL are exclusive states, so the flags can never
            // both be set, and a trigger leaves them and clears both flags.
            ok_r        <= (next_state_s == ST_PASS);
            err_r       <= (next_state_s == ST_FAIL);
        end
    end

    // Read-latency and retry-gap counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 2'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            // The strobe cycle counts as the first latency cycle.
            if ((state_r == ST_RD_ID) || (state_r == ST_RD_TS)) begin
                wait_cnt_r <= 2'd1;
            end else if ((state_r == ST_WT_ID) || (state_r == ST_WT_TS)) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end else begin
                wait_cnt_r <= 2'd0;
            end

            if (state_r == ST_CMP) begin
                gap_cnt_r <= GAP_LOAD_C;
            end else if ((state_r == ST_GAP) && (gap_cnt_r != 8'd0)) begin
                gap_cnt_r <= gap_cnt_r - 8'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    // Retry counter: cleared on trigger, bumped once per retried mismatch,
    // and therefore never exceeding MAX_RETRY.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_r <= 4'd0;
        end else if (trigger_s) begin
            retry_r <= 4'd0;
        end else if ((state_r == ST_CMP) && !match_s && can_retry_s) begin
            retry_r <= retry_r + 4'd1;
        end else begin
            retry_r <= retry_r;
        end
    end

    // Captured words; they persist across triggers until overwritten
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_r <= 32'd0;
            ts_r <= 32'd0;
        end else begin
            if (capture_id_s) begin
                id_r <= sysid_readdata;
            end else begin
                id_r <= id_r;
            end
            if (capture_ts_s) begin
                ts_r <= sysid_readdata;
            end else begin
                ts_r <= ts_r;
            end
        end
    end

    assign sysid_read    = read_r;
    assign sysid_address = addr_r;
    assign busy          = busy_r;
    assign sys_ok        = ok_r;
    assign sys_err       = err_r;
    assign id_word       = id_r;
    assign ts_word       = ts_r;
    assign retry_count   = retry_r;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for sysid_check_ctrl. Three instances cover the
// parameter corners:
//   u_a  defaults (latency 0, CHECK_TS=1, MAX_RETRY=3, RETRY_GAP=16, auto)
//   u_b  latency 2, CHECK_TS=0, EXPECTED_ID=0xCAFE0001, auto start
//   u_c  latency 1, MAX_RETRY=0, no auto start
// Each instance has a small slave model whose data is valid only in the
// cycle its latency dictates and is garbage otherwise.
// ---------------------------------------------------------------------------
module tb_sysid_check_ctrl;

    localparam logic [31:0] TS_GOOD = 32'd1571410521;
    localparam logic [31:0] ID_B    = 32'hCAFE_0001;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- instance a ----------------
    logic        start_a, addr_a, read_a, busy_a, ok_a, err_a;
    logic [31:0] rd_a, idw_a, tsw_a, id_val_a, ts_val_a;
    logic [3:0]  rc_a;
    logic        wrong_first_a, clr_a;
    int          id_reads_a = 0, last_ts_a = 0, min_gap_a = 9999;

    sysid_check_ctrl u_a (
        .clock(clock), .reset_n(reset_n), .start(start_a),
        .sysid_address(addr_a), .sysid_read(read_a), .sysid_readdata(rd_a),
        .busy(busy_a), .sys_ok(ok_a), .sys_err(err_a),
        .id_word(idw_a), .ts_word(tsw_a), .retry_count(rc_a)
    );

    // Zero-latency slave: data valid in the strobe cycle only
    always_comb begin
        if (!read_a)                             rd_a = 32'hFFFF_FFFF;
        else if (addr_a)                         rd_a = ts_val_a;
        else if (wrong_first_a && id_reads_a == 0) rd_a = 32'h0BAD_0000;
        else                                     rd_a = id_val_a;
    end

    // Count ID reads and track the smallest idle gap before a retry
    always @(posedge clock) begin
        if (clr_a) begin
            id_reads_a <= 0;
            min_gap_a  <= 9999;
        end else if (read_a && addr_a) begin
            last_ts_a <= cyc;
        end else if (read_a && !addr_a) begin
            id_reads_a <= id_reads_a + 1;
            if (id_reads_a > 0 && (cyc - last_ts_a - 1) < min_gap_a)
                min_gap_a <= cyc - last_ts_a - 1;
        end
    end

    // ---------------- instance b ----------------
    logic        start_b, addr_b, read_b, busy_b, ok_b, err_b;
    logic [31:0] rd_b, idw_b, tsw_b, id_val_b, ts_val_b;
    logic [3:0]  rc_b;
    logic [1:0]  pv_b, pa_b;
    logic        clr_b;
    int          id_reads_b = 0;

    sysid_check_ctrl #(
        .EXPECTED_ID(ID_B), .CHECK_TS(0), .READ_LATENCY(2),
        .MAX_RETRY(2), .RETRY_GAP(4), .AUTO_START(1)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .sysid_address(addr_b), .sysid_read(read_b), .sysid_readdata(rd_b),
        .busy(busy_b), .sys_ok(ok_b), .sys_err(err_b),
        .id_word(idw_b), .ts_word(tsw_b), .retry_count(rc_b)
    );

    // Two-cycle slave pipeline
    always @(posedge clock) begin
        if (!reset_n) begin
            pv_b <= 2'b00;
            pa_b <= 2'b00;
        end else begin
            pv_b <= {pv_b[0], read_b};
            pa_b <= {pa_b[0], addr_b};
        end
        if (clr_b) id_reads_b <= 0;
        else if (read_b && !addr_b) id_reads_b <= id_reads_b + 1;
    end
    assign rd_b = pv_b[1] ? (pa_b[1] ? ts_val_b : id_val_b) : 32'hBAD0_BAD0;

    // ---------------- instance c ----------------
    logic        start_c, addr_c, read_c, busy_c, ok_c, err_c;
    logic [31:0] rd_c, idw_c, tsw_c, id_val_c;
    logic [3:0]  rc_c;
    logic        pv_c, pa_c;

    sysid_check_ctrl #(
        .READ_LATENCY(1), .MAX_RETRY(0), .RETRY_GAP(1), .AUTO_START(0)
    ) u_c (
        .clock(clock), .reset_n(reset_n), .start(start_c),
        .sysid_address(addr_c), .sysid_read(read_c), .sysid_readdata(rd_c),
        .busy(busy_c), .sys_ok(ok_c), .sys_err(err_c),
        .id_word(idw_c), .ts_word(tsw_c), .retry_count(rc_c)
    );

    // One-cycle slave pipeline
    always @(posedge clock) begin
        if (!reset_n) begin
            pv_c <= 1'b0;
            pa_c <= 1'b0;
        end else begin
            pv_c <= read_c;
            pa_c <= addr_c;
        end
    end
    assign rd_c = pv_c ? (pa_c ? TS_GOOD : id_val_c) : 32'h5555_AAAA;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulse start on u_a and count edges (trigger edge included) to a result
    task automatic trig_a(input string tag, output int lat);
        @(negedge clock); start_a = 1'b1;
        @(posedge clock); #1; start_a = 1'b0; lat = 1;
        chk({tag, "_trig_clear"}, {28'd0, busy_a, ok_a, err_a, 1'b0} | {28'd0, rc_a}, 32'h8);
        while (!(ok_a || err_a) && lat < 300) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    // Same for u_b; a second start is pulsed at edge count noise_at (if >0)
    task automatic trig_b(input string tag, input int noise_at, output int lat);
        @(negedge clock); start_b = 1'b1;
        @(posedge clock); #1; start_b = 1'b0; lat = 1;
        chk({tag, "_trig_clear"}, {29'd0, busy_b, ok_b, err_b}, 32'h4);
        while (!(ok_b || err_b) && lat < 300) begin
            start_b = (lat == noise_at) ? 1'b1 : 1'b0;
            @(posedge clock); #1; lat++;
        end
        start_b = 1'b0;
    endtask

    task automatic trig_c(output int lat);
        @(negedge clock); start_c = 1'b1;
        @(posedge clock); #1; start_c = 1'b0; lat = 1;
        while (!(ok_c || err_c) && lat < 300) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    // ---------------- vector table for u_a ----------------
    typedef struct {
        logic [31:0] id_val;
        logic [31:0] ts_val;
        logic        wrong_first;
        logic        exp_ok;
        logic        exp_err;
        logic [3:0]  exp_retry;
        int          exp_lat;
        int          exp_reads;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;

        // first-try pass: 2*(0+1)+2 = 4; full failure: 4 + 3*(3+16) = 61;
        // pass on 2nd attempt: 4 + 19 = 23
        vecs[0] = '{32'd0,          TS_GOOD,       1'b0, 1'b1, 1'b0, 4'd0, 4,  1};
        vecs[1] = '{32'h1234_5678,  TS_GOOD,       1'b0, 1'b0, 1'b1, 4'd3, 61, 4};
        vecs[2] = '{32'd0,          32'h0000_0001, 1'b0, 1'b0, 1'b1, 4'd3, 61, 4};
        vecs[3] = '{32'd0,          TS_GOOD,       1'b1, 1'b1, 1'b0, 4'd1, 23, 2};
        vecs[4] = '{32'hFFFF_0000,  32'd7,         1'b0, 1'b0, 1'b1, 4'd3, 61, 4};

        reset_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        id_val_a = 32'd0; ts_val_a = TS_GOOD; wrong_first_a = 1'b0; clr_a = 1'b1;
        id_val_b = ID_B;  ts_val_b = 32'hDEAD_BEEF; clr_b = 1'b1;
        id_val_c = 32'd0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ctl_a", {25'd0, busy_a, ok_a, err_a, read_a, addr_a, 2'b00} | {28'd0, rc_a}, 32'd0);
        chk("rst_id_a", idw_a, 32'd0);
        chk("rst_ts_a", tsw_a, 32'd0);

        // Auto start after release: strobes on edges 1 and 2, sys_ok after 4
        @(negedge clock); reset_n = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        @(posedge clock); #1;
        chk("auto_rd_id", {29'd0, busy_a, read_a, addr_a}, 32'h6);
        @(posedge clock); #1;
        chk("auto_rd_ts", {30'd0, read_a, addr_a}, 32'h3);
        @(posedge clock); #1;
        chk("auto_cmp", {29'd0, read_a, addr_a, ok_a}, 32'h0);
        @(posedge clock); #1;
        chk("auto_ok", {29'd0, busy_a, ok_a, err_a}, 32'h2);
        chk("auto_id", idw_a, 32'd0);
        chk("auto_ts", tsw_a, TS_GOOD);
        // u_b (latency 2) auto check finishes after 8 edges
        repeat (3) @(posedge clock);
        #1;
        chk("auto_b_not_yet", {31'd0, ok_b}, 32'd0);
        @(posedge clock); #1;
        chk("auto_b_ok", {31'd0, ok_b}, 32'd1);
        chk("auto_b_id", idw_b, ID_B);
        chk("c_stays_idle", {29'd0, busy_c, ok_c, err_c} | {31'd0, read_c}, 32'd0);

        // Table-driven checks on u_a
        foreach (vecs[i]) begin
            @(negedge clock);
            id_val_a = vecs[i].id_val;
            ts_val_a = vecs[i].ts_val;
            wrong_first_a = vecs[i].wrong_first;
            clr_a = 1'b1;
            @(negedge clock); clr_a = 1'b0;
            trig_a($sformatf("v%0d", i), lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_flags", i), {30'd0, ok_a, err_a},
                {30'd0, vecs[i].exp_ok, vecs[i].exp_err});
            chk($sformatf("v%0d_busy", i), {31'd0, busy_a}, 32'd0);
            chk($sformatf("v%0d_retry", i), {28'd0, rc_a}, {28'd0, vecs[i].exp_retry});
            chk($sformatf("v%0d_id", i), idw_a, vecs[i].id_val);
            chk($sformatf("v%0d_ts", i), tsw_a, vecs[i].ts_val);
            chk($sformatf("v%0d_reads", i), 32'(id_reads_a), 32'(vecs[i].exp_reads));
            if (vecs[i].exp_reads > 1)
                chk($sformatf("v%0d_gap_ok", i), {31'd0, (min_gap_a >= 16)}, 32'd1);
        end

        // u_b: latency 2, garbage outside the valid cycle, start while busy ignored
        @(negedge clock); clr_b = 1'b1;
        @(negedge clock); clr_b = 1'b0;
        trig_b("b1", 3, lat);
        chk("b1_lat", 32'(lat), 32'd8);
        chk("b1_ok", {30'd0, ok_b, err_b}, 32'h2);
        chk("b1_id", idw_b, ID_B);
        chk("b1_ts", tsw_b, 32'hDEAD_BEEF);
        chk("b1_reads", 32'(id_reads_b), 32'd1);
        // start in PASS clears sys_ok (checked inside trig_b) and reruns
        ts_val_b = 32'h0123_4567;
        trig_b("b2", 0, lat);
        chk("b2_lat", 32'(lat), 32'd8);
        chk("b2_ok", {30'd0, ok_b, err_b}, 32'h2);
        chk("b2_ts", tsw_b, 32'h0123_4567);

        // u_b: reset during WT_TS aborts at once, release gives a fresh check
        @(negedge clock); start_b = 1'b1;
        @(posedge clock); #1; start_b = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("b3_busy_wt_ts", {30'd0, busy_b, read_b}, 32'h2);
        #2; reset_n = 1'b0;
        #1;
        chk("b3_rst_ctl", {25'd0, busy_b, ok_b, err_b, read_b, addr_b, 2'b00} | {28'd0, rc_b}, 32'd0);
        chk("b3_rst_id", idw_b, 32'd0);
        chk("b3_rst_ts", tsw_b, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        chk("b3_fresh_rd", {30'd0, read_b, addr_b}, 32'h2);
        lat = 1;
        while (!(ok_b || err_b) && lat < 300) begin
            @(posedge clock); #1; lat++;
        end
        chk("b3_lat", 32'(lat), 32'd8);
        chk("b3_ok", {31'd0, ok_b}, 32'd1);

        // u_c: MAX_RETRY=0, first mismatch fails; latency 2*(1+1)+2 = 6
        @(negedge clock); id_val_c = 32'h0000_0001;
        trig_c(lat);
        chk("c1_lat", 32'(lat), 32'd6);
        chk("c1_flags", {30'd0, ok_c, err_c}, 32'h1);
        chk("c1_retry", {28'd0, rc_c}, 32'd0);
        chk("c1_id", idw_c, 32'h0000_0001);
        @(negedge clock); id_val_c = 32'd0;
        trig_c(lat);
        chk("c2_lat", 32'(lat), 32'd6);
        chk("c2_flags", {30'd0, ok_c, err_c}, 32'h2);
        chk("c2_ts", tsw_c, TS_GOOD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
